// File: rtl/pn_pkg.sv
// Shared encodings for the Polish-notation stack evaluator: FSM states,
// operator codes, error codes and evaluation-order modes.
package pn_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  localparam int unsigned OP_ADD     = 0;
  localparam int unsigned OP_SUB     = 1;
  localparam int unsigned OP_MUL     = 2;
  localparam int unsigned OP_ABSDIFF = 3;
  localparam int unsigned OP_MAX     = 4;
  localparam int unsigned OP_MIN     = 5;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_UNDER = 2'd1;
  localparam logic [1:0] ERR_OVF   = 2'd2;
  localparam logic [1:0] ERR_MAL   = 2'd3;

  localparam logic MODE_PREFIX  = 1'b0;
  localparam logic MODE_POSTFIX = 1'b1;

endpackage

// File: rtl/pn_alu.sv
// Combinational operator unit: f(a,b,op) on signed DATA_W operands,
// wrapping modulo 2^DATA_W; unknown opcodes raise illegal.
module pn_alu
  import pn_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3
) (
  input  logic        [OP_W-1:0]   op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic        [DATA_W-1:0] res,
  output logic                     illegal
);

  always_comb begin
    res     = '0;
    illegal = 1'b0;
    case (32'(op))
      OP_ADD:     res = a + b;
      OP_SUB:     res = a - b;
      OP_MUL:     res = a * b;
      OP_ABSDIFF: res = (a > b) ? a - b : b - a;
      OP_MAX:     res = (a > b) ? a : b;
      OP_MIN:     res = (a < b) ? a : b;
      default:    illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/pn_stack_eval.sv
// Frame-buffered Polish-notation evaluator: loads one token per cycle, then
// walks the buffer (prefix or postfix order) over an operand stack.
module pn_stack_eval
  import pn_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned IN_W    = 3,
  parameter int unsigned MAX_TOK = 16,
  parameter int unsigned STACK_D = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              mode,
  input  logic              operator,
  input  logic [IN_W-1:0]   in,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out,
  output logic [1:0]        err
);

  localparam int unsigned CW  = $clog2(MAX_TOK + 1);
  localparam int unsigned IW  = (MAX_TOK > 1) ? $clog2(MAX_TOK) : 1;
  localparam int unsigned SPW = $clog2(STACK_D + 1);
  localparam int unsigned SW  = (STACK_D > 1) ? $clog2(STACK_D) : 1;

  // Token layout: {is_operator, value/opcode}
  typedef logic [IN_W:0] tok_t;

  state_t            state_q, state_d;
  tok_t              tok_q [MAX_TOK];
  tok_t              tok_d [MAX_TOK];
  logic [DATA_W-1:0] stk_q [STACK_D];
  logic [DATA_W-1:0] stk_d [STACK_D];
  logic [CW-1:0]     cnt_q, cnt_d, ev_q, ev_d;
  logic [SPW-1:0]    sp_q, sp_d;
  logic              mode_q, mode_d, ovf_q, ovf_d;
  logic              in_ready_q, in_ready_d, out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_q, out_d;
  logic [1:0]        err_q, err_d;

  logic [CW-1:0]     rd_idx;
  tok_t              cur_tok;
  logic [DATA_W-1:0] top_v, deep_v, alu_a, alu_b, alu_res, push_v;
  logic              alu_ill, postfix;
  logic [1:0]        err_n;

  assign postfix = (mode_q == MODE_POSTFIX);

  always_comb begin
    rd_idx  = postfix ? ev_q : cnt_q - CW'(1) - ev_q;
    cur_tok = tok_q[IW'(rd_idx)];
    top_v   = stk_q[SW'(sp_q - SPW'(1))];
    deep_v  = stk_q[SW'(sp_q - SPW'(2))];
    alu_a   = postfix ? deep_v : top_v;
    alu_b   = postfix ? top_v  : deep_v;
  end

  pn_alu #(.DATA_W(DATA_W), .OP_W(IN_W)) u_alu (
    .op      (cur_tok[IN_W-1:0]),
    .a       (alu_a),
    .b       (alu_b),
    .res     (alu_res),
    .illegal (alu_ill)
  );

  always_comb begin
    state_d     = state_q;
    tok_d       = tok_q;
    stk_d       = stk_q;
    cnt_d       = cnt_q;
    ev_d        = ev_q;
    sp_d        = sp_q;
    mode_d      = mode_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    out_d       = '0;
    err_d       = ERR_OK;
    err_n       = ERR_OK;
    push_v      = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        sp_d  = '0;
        if (in_valid) begin
          tok_d[0] = {operator, in};
          cnt_d    = CW'(1);
          mode_d   = mode;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (cnt_q == CW'(MAX_TOK)) begin
            ovf_d = 1'b1;
          end else begin
            tok_d[IW'(cnt_q)] = {operator, in};
            cnt_d             = cnt_q + CW'(1);
          end
        end else if (ovf_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          err_d       = ERR_OVF;
        end else begin
          state_d = EVAL;
          ev_d    = '0;
          sp_d    = '0;
        end
      end
      EVAL: begin
        if (!cur_tok[IN_W]) begin
          push_v = DATA_W'(cur_tok[IN_W-1:0]);
          if (sp_q == SPW'(STACK_D)) begin
            err_n = ERR_OVF;
          end else begin
            stk_d[SW'(sp_q)] = push_v;
            sp_d             = sp_q + SPW'(1);
          end
        end else if (sp_q < SPW'(2)) begin
          err_n = ERR_UNDER;
        end else if (alu_ill) begin
          err_n = ERR_MAL;
        end else begin
          push_v                      = alu_res;
          stk_d[SW'(sp_q - SPW'(2))] = alu_res;
          sp_d                        = sp_q - SPW'(1);
        end
        ev_d = ev_q + CW'(1);
        // With sp ending at 1, the value pushed this cycle is stack[0].
        if (err_n != ERR_OK) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          err_d       = err_n;
        end else if (ev_q == cnt_q - CW'(1)) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          if (sp_d == SPW'(1)) out_d = push_v;
          else                 err_d = ERR_MAL;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        sp_d    = '0;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == IDLE) || (state_d == LOAD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      ev_q        <= '0;
      sp_q        <= '0;
      mode_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= ERR_OK;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ev_q        <= ev_d;
      sp_q        <= sp_d;
      mode_q      <= mode_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      err_q       <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    tok_q <= tok_d;
    stk_q <= stk_d;
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign err       = err_q;

endmodule

// File: tb/tb_pn_stack_eval.sv
// Scoreboard bench for pn_stack_eval: directed frames with hand-derived
// results plus random frames checked against a small software stack model.
module tb_pn_stack_eval;

  localparam int DATA_W  = 32;
  localparam int IN_W    = 3;
  localparam int MAX_TOK = 16;
  localparam int STACK_D = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              mode = 1'b0;
  logic              operator = 1'b0;
  logic [IN_W-1:0]   din = '0;
  logic              in_ready, out_valid;
  logic [DATA_W-1:0] dout;
  logic [1:0]        err;

  typedef struct {
    logic [31:0] out;
    logic [1:0]  err;
    int          due;
  } exp_t;

  exp_t       sb[$];
  exp_t       e_mon;
  logic [3:0] frm[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;

  pn_stack_eval #(.DATA_W(DATA_W), .IN_W(IN_W), .MAX_TOK(MAX_TOK), .STACK_D(STACK_D)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .mode      (mode),
    .operator  (operator),
    .in        (din),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out       (dout),
    .err       (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("out", dout, e_mon.out);
          chk("err", err, e_mon.err);
          chk("latency", cyc, e_mon.due);
        end
      end else begin
        chk("idle_out_err_zero", {err, dout}, '0);
      end
    end
  end

  // Reference evaluator; lat is the c-index of the expected out_valid cycle.
  function automatic void model(input bit md, output logic [31:0] o,
                                output logic [1:0] e, output int lat);
    logic signed [31:0] st[$];
    int n = frm.size();
    o = '0;
    e = 2'd0;
    if (n > MAX_TOK) begin
      e = 2'd2; lat = 1; return;
    end
    lat = n + 1;
    for (int j = 0; j < n; j++) begin
      logic [3:0] t = frm[md ? j : n - 1 - j];
      if (!t[3]) begin
        if (st.size() == STACK_D) begin
          e = 2'd2; lat = j + 2; return;
        end
        st.push_back(32'(t[2:0]));
      end else begin
        logic signed [31:0] top, dp, a, b, r;
        if (st.size() < 2) begin
          e = 2'd1; lat = j + 2; return;
        end
        top = st.pop_back();
        dp  = st.pop_back();
        a = md ? dp : top;
        b = md ? top : dp;
        case (t[2:0])
          3'd0: r = a + b;
          3'd1: r = a - b;
          3'd2: r = a * b;
          3'd3: r = (a > b) ? a - b : b - a;
          3'd4: r = (a > b) ? a : b;
          3'd5: r = (a < b) ? a : b;
          default: begin e = 2'd3; lat = j + 2; return; end
        endcase
        st.push_back(r);
      end
    end
    if (st.size() != 1) e = 2'd3;
    else                o = st[0];
  endfunction

  // Called at a negedge; returns at the negedge right after the out_valid cycle.
  task automatic run_frame(input bit md, input logic [31:0] eo, input logic [1:0] ee,
                           input int lat, input bit pulses);
    int c0 = cyc;
    int n  = frm.size();
    exp_t x;
    x.out = eo; x.err = ee; x.due = c0 + n + lat;
    sb.push_back(x);
    for (int k = 0; k < n; k++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1'b1;
      mode     = (k == 0) ? md : ~md;
      operator = frm[k][3];
      din      = frm[k][2:0];
      @(negedge clk);
    end
    in_valid = 1'b0;
    for (int j = 1; j <= lat; j++) begin
      @(negedge clk);
      chk("in_ready_busy", in_ready, 0);
      if (pulses && j < lat) begin
        in_valid = j[0];
        operator = 1'b0;
        din      = IN_W'($urandom_range(0, 7));
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_model(input bit md, input bit pulses);
    logic [31:0] o;
    logic [1:0]  e;
    int          lat;
    model(md, o, e, lat);
    run_frame(md, o, e, lat, pulses);
  endtask

  task automatic rst_pulse();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_err", {err, dout}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_pulse();

    frm = '{4'h3, 4'h4, 4'h8, 4'h2, 4'hA};
    run_frame(1'b1, 32'd14, 2'd0, 6, 1'b0);
    frm = '{4'h9, 4'h2, 4'hA, 4'h3, 4'h4};
    run_frame(1'b0, 32'hFFFF_FFF6, 2'd0, 6, 1'b1);
    frm = '{4'h2, 4'h7, 4'hB};
    run_frame(1'b1, 32'd5, 2'd0, 4, 1'b0);
    frm = '{4'h2, 4'h7, 4'hD};
    run_frame(1'b1, 32'd2, 2'd0, 4, 1'b1);
    frm = '{4'h2, 4'h7, 4'hE};
    run_frame(1'b1, 32'd0, 2'd3, 4, 1'b0);
    frm = '{4'h2, 4'h7, 4'hC};
    run_frame(1'b1, 32'd7, 2'd0, 4, 1'b0);
    frm = '{4'h2, 4'h7, 4'h9};
    run_frame(1'b1, 32'hFFFF_FFFB, 2'd0, 4, 1'b0);
    frm = '{4'h5, 4'h8};
    run_frame(1'b1, 32'd0, 2'd1, 3, 1'b0);
    frm = '{4'h1, 4'h2, 4'h3, 4'h8};
    run_frame(1'b1, 32'd0, 2'd3, 5, 1'b0);
    frm = '{4'h5};
    run_frame(1'b1, 32'd5, 2'd0, 2, 1'b0);
    frm = '{4'hF, 4'h1, 4'h2};
    run_frame(1'b0, 32'd0, 2'd3, 4, 1'b0);
    frm = '{4'h8, 4'h3};
    run_frame(1'b0, 32'd0, 2'd1, 3, 1'b0);

    frm.delete();
    for (int i = 0; i < 17; i++) frm.push_back(4'h7);
    run_frame(1'b1, 32'd0, 2'd2, 1, 1'b1);
    frm.delete();
    for (int i = 0; i < 9; i++) frm.push_back(4'h1);
    run_frame(1'b1, 32'd0, 2'd2, 10, 1'b0);
    frm.delete();
    for (int i = 0; i < 8; i++) frm.push_back(4'h7);
    for (int i = 0; i < 7; i++) frm.push_back(4'h8);
    run_frame(1'b1, 32'd56, 2'd0, 16, 1'b0);

    // Reset mid-LOAD: partial frame must vanish without a result.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; operator = 1'b0; din = 3'd6; mode = 1'b1;
      @(negedge clk);
    end
    rst_pulse();
    frm = '{4'h3, 4'h4, 4'h8, 4'h2, 4'hA};
    run_frame(1'b1, 32'd14, 2'd0, 6, 1'b0);

    // Reset mid-EVAL.
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; operator = frm[k][3]; din = frm[k][2:0]; mode = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_pulse();
    repeat (10) @(negedge clk);
    frm = '{4'h9, 4'h2, 4'hA, 4'h3, 4'h4};
    run_frame(1'b0, 32'hFFFF_FFF6, 2'd0, 6, 1'b0);

    for (int r = 0; r < 8; r++) begin
      int n = $urandom_range(1, 9);
      frm.delete();
      for (int k = 0; k < n; k++) begin
        logic [3:0] t;
        t[3]   = ($urandom_range(0, 2) == 0);
        t[2:0] = 3'($urandom_range(0, 7));
        frm.push_back(t);
      end
      run_model(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    for (int w = 0; w < 50 && sb.size() != 0; w++) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pn_stack_eval.md
Name: pn_stack_eval

Overview:
- Parametrised Polish-notation evaluator that accepts one token per cycle as a frame and buffers it.
- Evaluates the frame on an internal operand stack in either prefix or postfix order, one token per cycle.
- Returns a single signed result with an error code.
- Successor to the fixed 12-token PN block: adds generic widths and depths, an in_ready handshake, underflow/overflow/malformed-expression detection, and defined operator semantics.

Parameters:
DATA_W, 32, result and stack-entry width (two's complement)
IN_W, 3, token field width (operand value or operator code)
MAX_TOK, 16, token buffer depth per frame
STACK_D, 8, operand stack depth

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_valid  in  1  token valid; a frame is a contiguous run of in_valid cycles
mode  in  1  0 = prefix, 1 = postfix; sampled on the first token of a frame only
operator  in  1  1 = token is an operator, 0 = operand
in  in  IN_W  operand value (unsigned) or operator code
in_ready  out  1  high in IDLE/LOAD; tokens presented while low are ignored
out_valid  out  1  one-cycle result strobe
out  out  DATA_W  signed result; 0 when err != 0
err  out  2  0 = ok, 1 = stack underflow, 2 = overflow (token or stack), 3 = malformed/illegal

Behaviour:
- Reset (any time, including mid-frame or mid-eval): state IDLE; partial frame discarded; out_valid=0, out=0, err=0, in_ready=1; token count and sp cleared.
- States: IDLE -> LOAD on in_valid (capture token 0 and mode); LOAD stays while in_valid; LOAD -> EVAL on first cycle with in_valid low (cycle c0); EVAL -> DONE after the last token or on the first error; DONE -> IDLE unconditionally.
- Load: tokens are written at index 0..N-1.
  - Tokens beyond MAX_TOK are dropped and set a sticky token-overflow flag.
- Eval order: postfix reads index 0 up to N-1; prefix reads N-1 down to 0. One token per cycle during c1..cN.
- Operand: zero-extended to DATA_W and pushed; a push with sp==STACK_D is err=2.
- Operator:
  - Pops two entries; sp<2 is err=1.
  - Postfix: a = deeper entry, b = top. Prefix: a = top, b = deeper.
  - Pushes f(a,b): 0 a+b; 1 a-b; 2 a*b (low DATA_W bits); 3 |a-b|; 4 max(a,b); 5 min(a,b) (signed compare); 6-7 illegal, err=3.
  - All arithmetic wraps modulo 2^DATA_W.
- Completion: after token N, sp must equal 1, otherwise err=3. out = stack[0].
- Latency:
  - Error-free: out_valid high in cycle c(N+1).
  - Error at token k: eval aborts and out_valid is high in c(k+1).
  - Token overflow: no eval; out_valid in c1 with err=2.
- Error priority: the first error detected wins; out=0 whenever err != 0.
- Handshake: in_ready low from c1 through the out_valid cycle. in_valid in that window is ignored, not queued. A new frame may start the cycle after out_valid.
- out/err hold their value only during out_valid and are 0 otherwise.

Decomposition:
- Package pn_pkg:
  - operator-code constants (OP_ADD..OP_MIN)
  - error-code constants
  - FSM state encoding (IDLE, LOAD, EVAL, DONE)
  - mode constants
- Sub-module pn_alu: combinational f(a,b,op) returning result and illegal flag, parametrised by DATA_W.
- The token buffer, stack and FSM stay in pn_stack_eval.

Test Plan:
- Postfix mode=1, tokens (op,in): (0,3)(0,4)(1,0)(0,2)(1,2) -> out=14, err=0, out_valid in c6, single cycle.
- Prefix mode=0: (1,1)(0,2)(1,2)(0,3)(0,4) -> evaluates 2-(3*4), out=-10 (0xFFFFFFF6), err=0.
- Postfix (0,2)(0,7)(1,3) -> out=5; (0,2)(0,7)(1,5) -> out=2; (0,2)(0,7)(1,6) -> err=3, out=0.
- Underflow: postfix (0,5)(1,0) -> err=1, out=0, out_valid in c3. Malformed: (0,1)(0,2)(0,3)(1,0) -> err=3, out_valid in c5.
- Overflow:
  - 17 operand tokens with MAX_TOK=16 -> err=2, out_valid in c1.
  - 9 operands with STACK_D=8 -> err=2 at token 9.
- Back-to-back frames with in_valid pulses during EVAL -> pulses ignored, in_ready low.
- rst pulse mid-LOAD and mid-EVAL -> no out_valid; the next frame evaluates correctly.
